// File: rtl/best_nonce_pkg.sv
// rtl/best_nonce_pkg.sv - shared constants, states and address map for the best-nonce writer/reporter
package best_nonce_pkg;

   // Number of 16-bit nonce words stored at RAM addresses 0..NONCE_LENGTH-1
   localparam int NONCE_LENGTH = 8;

   // Result RAM address map
   localparam logic [3:0] ADDR_NONCE_BASE        = 4'h0;
   localparam logic [3:0] ADDR_BEST_CORE_ID_LOW  = 4'h8;
   localparam logic [3:0] ADDR_BEST_CORE_ID_HIGH = 4'h9;
   localparam logic [3:0] ADDR_BEST_BITS_OFF     = 4'hA;
   localparam logic [3:0] ADDR_NEW_CORE_ID_LOW   = 4'hB;

   // Bits-off value of a record that has never been written
   localparam logic [15:0] NO_RESULT_BITS_OFF = 16'd1023;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_ADDR,
      ST_LATCH,
      ST_SEND_HI,
      ST_SEND_LO,
      ST_DONE
   } report_state_t;

   // Record word index to RAM address: bits off, core ID high, core ID low, then nonce words
   function automatic logic [3:0] word_address(input logic [3:0] w);
      logic [3:0] addr;
      case (w)
         4'd0:    addr = ADDR_BEST_BITS_OFF;
         4'd1:    addr = ADDR_BEST_CORE_ID_HIGH;
         4'd2:    addr = ADDR_BEST_CORE_ID_LOW;
         default: addr = ADDR_NONCE_BASE + (w - 4'd3);
      endcase
      return addr;
   endfunction

endpackage

// File: rtl/best_nonce_reporter_if.sv
// rtl/best_nonce_reporter_if.sv - byte stream from the reporter to the host transmitter
interface best_nonce_reporter_if;
   logic [7:0] tx_data_o;
   logic       tx_valid_o;
   logic       tx_ready_i;

   modport master (
      output tx_data_o,
      output tx_valid_o,
      input  tx_ready_i
   );

   modport slave (
      input  tx_data_o,
      input  tx_valid_o,
      output tx_ready_i
   );
endinterface

// File: rtl/best_nonce_reporter.sv
// rtl/best_nonce_reporter.sv - serialises the best-result record from the result RAM as a byte frame
module best_nonce_reporter #(
   parameter int         NONCE_LENGTH = best_nonce_pkg::NONCE_LENGTH,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5,
   parameter int         RAM_LATENCY  = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           report_request_i,
   input  logic [15:0]                    ram_i,
   output logic [3:0]                     ram_address_o,
   best_nonce_reporter_if.master          tx,
   output logic                           busy_o,
   output logic                           done_o
);
   import best_nonce_pkg::*;

   // Index of the final record word; the record never spans more than 16 words
   localparam logic [3:0] LAST_WORD = 4'(NONCE_LENGTH + 2);

   // The ADDR/LATCH pair assumes read data arrives exactly one cycle after the address
   generate
      if (RAM_LATENCY != 1 || NONCE_LENGTH < 1 || NONCE_LENGTH + 2 > 15) begin : g_bad_cfg
         $error("best_nonce_reporter: RAM_LATENCY must be 1 and NONCE_LENGTH in 1..13");
      end
   endgenerate

   report_state_t state_q, state_d;
   logic [3:0]    word_idx_q, word_idx_d;
   logic [15:0]   word_q, word_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_valid_q, tx_valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   // Next-state logic; outputs are derived from the next state so they leave registers
   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      word_d     = word_q;

      case (state_q)
         ST_IDLE: begin
            if (report_request_i) state_d = ST_SYNC;
         end
         ST_SYNC: begin
            if (tx.tx_ready_i) state_d = ST_ADDR;
         end
         ST_ADDR: begin
            state_d = ST_LATCH;
         end
         ST_LATCH: begin
            word_d  = ram_i;
            state_d = ST_SEND_HI;
         end
         ST_SEND_HI: begin
            if (tx.tx_ready_i) state_d = ST_SEND_LO;
         end
         ST_SEND_LO: begin
            if (tx.tx_ready_i) begin
               if (word_idx_q == LAST_WORD) begin
                  state_d = ST_DONE;
               end else begin
                  word_idx_d = word_idx_q + 4'd1;
                  state_d    = ST_ADDR;
               end
            end
         end
         ST_DONE: begin
            word_idx_d = 4'd0;
            state_d    = ST_IDLE;
         end
         default: begin
            word_idx_d = 4'd0;
            state_d    = ST_IDLE;
         end
      endcase

      tx_valid_d = (state_d == ST_SYNC) || (state_d == ST_SEND_HI) || (state_d == ST_SEND_LO);

      case (state_d)
         ST_SYNC:    tx_data_d = SYNC_BYTE;
         ST_SEND_HI: tx_data_d = word_d[15:8];
         ST_SEND_LO: tx_data_d = word_d[7:0];
         default:    tx_data_d = 8'h00;
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // State and registered outputs; reset abandons any frame in flight
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         word_idx_q <= 4'd0;
         word_q     <= 16'h0000;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_idx_q <= word_idx_d;
         word_q     <= word_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign ram_address_o = word_address(word_idx_q);
   assign tx.tx_data_o  = tx_data_q;
   assign tx.tx_valid_o = tx_valid_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;

endmodule

// File: tb/tb_best_nonce_reporter.sv
// tb/tb_best_nonce_reporter.sv - self-checking bench for best_nonce_reporter
module tb_best_nonce_reporter;
   import best_nonce_pkg::*;

   localparam int FRAME_LEN = 1 + 2 * (NONCE_LENGTH + 3);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic [15:0] ram_i;
   logic [3:0]  ram_addr;
   logic        busy;
   logic        done;

   best_nonce_reporter_if tx_if ();

   best_nonce_reporter dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .report_request_i (req),
      .ram_i            (ram_i),
      .ram_address_o    (ram_addr),
      .tx               (tx_if),
      .busy_o           (busy),
      .done_o           (done)
   );

   always #5 clk = ~clk;

   // RAM model: registered read, optional garbage on the data bus outside the sample point
   logic [15:0] mem [16];
   logic [15:0] ram_q;
   logic [15:0] garbage;
   bit          glitch = 1'b0;
   int          lat_cnt = 0;

   always @(posedge clk) begin
      ram_q   <= mem[ram_addr];
      garbage <= 16'($urandom);
   end

   assign ram_i = (glitch && lat_cnt != 3) ? garbage : ram_q;

   // Sink ready pattern: 0 = always ready, 1 = coin flip, 2 = mostly stalled
   int ready_mode = 0;
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       tx_if.tx_ready_i = 1'b1;
         1:       tx_if.tx_ready_i = ($urandom_range(0, 1) == 1);
         default: tx_if.tx_ready_i = ($urandom_range(0, 3) == 0);
      endcase
   end

   int checks = 0;
   int failures = 0;

   logic [7:0] got [$];
   logic [7:0] exp_q [$];
   int         done_cnt = 0;
   int         stab_err = 0;
   bit         prev_hold = 1'b0;
   logic [7:0] prev_data = 8'h00;

   // Monitor at mid-cycle: collects accepted bytes, checks hold stability, tracks the RAM sample cycle
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold = 1'b0;
         lat_cnt   = 0;
      end else begin
         if (prev_hold && (!tx_if.tx_valid_o || tx_if.tx_data_o != prev_data)) stab_err++;
         if (lat_cnt == 1) lat_cnt = 2;
         else if (lat_cnt == 2) lat_cnt = 3;
         else lat_cnt = 0;
         if (tx_if.tx_valid_o && tx_if.tx_ready_i) begin
            // After the sync byte or a low byte another word is fetched: one address cycle, then the sample cycle
            if ((got.size() % 2 == 0) && got.size() < FRAME_LEN - 1) lat_cnt = 1;
            got.push_back(tx_if.tx_data_o);
         end
         prev_hold = tx_if.tx_valid_o && !tx_if.tx_ready_i;
         prev_data = tx_if.tx_data_o;
         if (done) done_cnt++;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic load_mem(input int kind, input logic [15:0] bits_off);
      for (int i = 0; i < 16; i++) mem[i] = (kind == 2) ? 16'($urandom) : 16'h0000;
      if (kind == 0) begin
         mem[9] = 16'h0045;
         mem[8] = 16'h6789;
         for (int i = 0; i < NONCE_LENGTH; i++) mem[i] = 16'h1000 + 16'(i);
      end
      mem[10] = bits_off;
   endtask

   task automatic push_word(input logic [15:0] w);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
   endtask

   // Reference frame: sync, bits off, core ID high, core ID low, nonce words in order
   task automatic build_expected();
      exp_q.delete();
      exp_q.push_back(8'hA5);
      push_word(mem[10]);
      push_word(mem[9]);
      push_word(mem[8]);
      for (int i = 0; i < NONCE_LENGTH; i++) push_word(mem[i]);
   endtask

   task automatic start_req();
      @(posedge clk); #1 req = 1'b1;
      @(posedge clk); #1 req = 1'b0;
   endtask

   // Waits for done; optionally fires ignored requests at byte 5 and in the DONE cycle
   task automatic wait_done(input bit extra, output int cycles);
      bit sent5 = 1'b0;
      cycles = 0;
      while (done_cnt == 0 && cycles < 3000) begin
         @(negedge clk); #1;
         cycles++;
         if (extra && !sent5 && got.size() == 5) begin
            sent5 = 1'b1;
            req = 1'b1;
            @(posedge clk); #1 req = 1'b0;
         end
      end
      if (done_cnt == 0) begin
         failures++;
         checks++;
         $display("FAIL done_timeout actual=none expected=done_o pulse");
      end else if (extra) begin
         req = 1'b1;
         @(posedge clk); #1 req = 1'b0;
      end
   endtask

   task automatic check_frame(input string name);
      chk({name, "_len"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got.size()) chk($sformatf("%s_byte%0d", name, i), got[i], exp_q[i]);
      end
      chk({name, "_stable"}, stab_err, 0);
      chk({name, "_done_once"}, done_cnt, 1);
      chk({name, "_busy_low"}, busy, 0);
      chk({name, "_valid_low"}, tx_if.tx_valid_o, 0);
   endtask

   typedef struct {
      int          rmode;
      bit          glitch;
      int          kind;
      logic [15:0] bits_off;
      bit          extra;
      logic [7:0]  exp_b1;
      logic [7:0]  exp_b2;
      int          exp_len;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int cyc;

      vecs[0] = '{0, 1'b0, 0, 16'h0123, 1'b0, 8'h01, 8'h23, 23};
      vecs[1] = '{1, 1'b0, 0, 16'h0123, 1'b0, 8'h01, 8'h23, 23};
      vecs[2] = '{1, 1'b0, 0, 16'h0123, 1'b1, 8'h01, 8'h23, 23};
      vecs[3] = '{0, 1'b1, 2, 16'h02C7, 1'b0, 8'h02, 8'hC7, 23};
      vecs[4] = '{1, 1'b1, 2, 16'h0001, 1'b0, 8'h00, 8'h01, 23};
      vecs[5] = '{0, 1'b0, 1, NO_RESULT_BITS_OFF, 1'b0, 8'h03, 8'hFF, 23};
      vecs[6] = '{2, 1'b1, 0, 16'h0123, 1'b0, 8'h01, 8'h23, 23};

      load_mem(0, 16'h0123);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", tx_if.tx_valid_o, 0);
      chk("rst_data", tx_if.tx_data_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", ram_addr, 4'hA);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Table-driven frames
      for (int v = 0; v < 7; v++) begin
         ready_mode = vecs[v].rmode;
         glitch     = vecs[v].glitch;
         load_mem(vecs[v].kind, vecs[v].bits_off);
         build_expected();
         got.delete();
         done_cnt = 0;
         stab_err = 0;
         start_req();
         wait_done(vecs[v].extra, cyc);
         if (vecs[v].rmode == 0) chk($sformatf("v%0d_latency", v), cyc, 46);
         repeat (6) @(posedge clk);
         #1;
         chk($sformatf("v%0d_len_table", v), got.size(), vecs[v].exp_len);
         if (got.size() >= 3) begin
            chk($sformatf("v%0d_b1", v), got[1], vecs[v].exp_b1);
            chk($sformatf("v%0d_b2", v), got[2], vecs[v].exp_b2);
         end
         check_frame($sformatf("v%0d", v));
      end
      glitch = 1'b0;

      // Back-to-back: request in the IDLE cycle right after DONE starts a new frame
      ready_mode = 0;
      load_mem(0, 16'h0123);
      build_expected();
      got.delete();
      done_cnt = 0;
      stab_err = 0;
      start_req();
      wait_done(1'b0, cyc);
      chk("b2b_first_len", got.size(), FRAME_LEN);
      @(posedge clk); #1 req = 1'b1;
      @(posedge clk); #1 req = 1'b0;
      chk("b2b_busy", busy, 1);
      got.delete();
      done_cnt = 0;
      wait_done(1'b0, cyc);
      repeat (4) @(posedge clk);
      #1;
      check_frame("b2b");

      // Reset while the low byte of word 4 is pending
      ready_mode = 2;
      got.delete();
      done_cnt = 0;
      stab_err = 0;
      start_req();
      cyc = 0;
      while (got.size() < 10 && cyc < 2000) begin
         @(negedge clk); #1;
         cyc++;
      end
      chk("rst_mid_reached", got.size(), 10);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", tx_if.tx_valid_o, 0);
      chk("rst_mid_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      ready_mode = 0;
      repeat (10) @(posedge clk);
      #1;
      chk("rst_mid_no_bytes", got.size(), 10);
      chk("rst_mid_idle_busy", busy, 0);
      got.delete();
      done_cnt = 0;
      stab_err = 0;
      start_req();
      wait_done(1'b0, cyc);
      repeat (4) @(posedge clk);
      #1;
      check_frame("after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/best_nonce_reporter.md
Name: best_nonce_reporter

Overview:
Reads the best-result record back out of the 16x16 result RAM that the best-nonce writer fills. It serialises that record to the host as a byte stream over a valid/ready handshake, for example into the UART transmitter. The record is bits-off, core ID and nonce. The block sits on the RAM read port, opposite the writer. The top level uses busy_o to hold off writer saves while a report is in flight.

Parameters:
NONCE_LENGTH, 8, number of 16-bit nonce words (RAM addresses 0..NONCE_LENGTH-1).
SYNC_BYTE, 8'hA5, frame-start byte sent before the record.
RAM_LATENCY, 1, cycles from ram_address_o to valid ram_i (only 1 is supported; elaborate-time check).

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous active-low reset
report_request_i  in  1  one-cycle pulse: start a report
ram_i  in  16  RAM read data, valid 1 cycle after address
ram_address_o  out  4  RAM read address
tx_data_o  out  8  byte to host
tx_valid_o  out  1  tx_data_o valid; held until accepted
tx_ready_i  in  1  sink accepts byte when valid and ready in the same cycle
busy_o  out  1  high from request acceptance through done_o
done_o  out  1  one-cycle pulse after last byte accepted

Behaviour:
- Reset (rst_ni low, asynchronous):
  - State IDLE, word index 0.
  - tx_valid_o=0, tx_data_o=0, busy_o=0, done_o=0.
  - ram_address_o=4'hA.
  - Reset mid-report abandons the frame immediately, with no further bytes.
- Record order, word index w = 0..NONCE_LENGTH+2:
  - w0: addr 4'hA (bits off).
  - w1: 4'h9 (core ID high; upper byte 0).
  - w2: 4'h8 (core ID low).
  - w3..: addr w-3 (nonce words 0..7).
  - ram_address_o is combinational from the state and w.
- Frame: SYNC_BYTE, then every word as two bytes, high byte first.
  - 1 + 2*(NONCE_LENGTH+3) = 23 bytes with defaults.
- States:
  - IDLE: report_request_i=1 → SYNC, busy_o=1 next cycle.
  - SYNC: tx_valid_o=1, tx_data_o=SYNC_BYTE. On accept → ADDR.
  - ADDR: present the address for w. → LATCH.
  - LATCH: capture ram_i into word_q. → SEND_HI.
  - SEND_HI: tx_data_o=word_q[15:8], valid. On accept → SEND_LO.
  - SEND_LO: tx_data_o=word_q[7:0], valid. On accept: if w is last → DONE, else w+1 → ADDR.
  - DONE: done_o=1, busy_o=1. → IDLE, w=0.
- Handshake rules:
  - Once tx_valid_o rises, tx_data_o is stable and tx_valid_o stays high until accepted.
  - Any number of stall cycles is allowed.
  - tx_valid_o is low in ADDR, LATCH, DONE and IDLE.
- Latency:
  - Request at edge k gives SYNC valid from cycle k+1.
  - With tx_ready_i tied high, the frame takes 1 + 4*(NONCE_LENGTH+3) cycles: 45, plus the DONE cycle.
- Boundary conditions:
  - report_request_i while busy: ignored, no queuing.
  - report_request_i in the DONE cycle: ignored.
  - A request in IDLE in the cycle after DONE is accepted.
  - ram_i is sampled only in LATCH. Changes at other times have no effect.
  - An unwritten record (bits off 1023 = 16'h03FF) is reported verbatim; the host interprets it.
  - The word index width is 4 bits. The last index is NONCE_LENGTH+2, which is ≤ 15 so no wrap occurs.

Decomposition:
- Shared package (best_nonce_pkg), used by the writer and this block:
  - RAM address constants: NONCE base 0, BEST_CORE_ID_LOW 8, BEST_CORE_ID_HIGH 9, BEST_BITS_OFF A, NEW_CORE_ID_LOW B.
  - NONCE_LENGTH.
  - The 1023 "no result" value.
- No sub-module needed. The word-index-to-address mapping is a function in the package.

Test Plan:
- Preload RAM: A=16'h0123, 9=16'h0045, 8=16'h6789, 0..7=16'h1000+i. Pulse request with tx_ready_i=1. Expect bytes A5,01,23,00,45,67,89,10,00,10,01,…,10,07 (23 bytes), then done_o pulses once and busy_o falls.
- Same frame with tx_ready_i toggling on a pseudo-random pattern: identical byte sequence, tx_data_o stable whenever valid is held, no drops or duplicates.
- Second report_request_i pulses during byte 5 and in the DONE cycle: ignored, exactly one 23-byte frame. A pulse one cycle after DONE starts a new frame.
- rst_ni low during SEND_LO of w4: tx_valid_o and busy_o drop asynchronously. After release, no bytes until a new request. The new request yields a full frame starting with A5.
- Change ram_i on the RAM model outside LATCH cycles (glitch data): reported bytes match the RAM contents at the LATCH sample only.
- Erased record (A=16'h03FF, others 0): bytes A5,03,FF followed by 20 zero bytes.
